// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder response checker family.
//   state_e : checker FSM encodings
//   nvec_f  : number of vectors in an exhaustive sweep of a W-bit adder
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Exhaustive sweep covers every {a,b,cin} combination: 2**(2W+1).
    function automatic int unsigned nvec_f(input int unsigned w);
        return 32'd1 << (2 * w + 1);
    endfunction

endpackage

// File: rtl/adder_golden.sv
// Golden reference adder: {gc,gz} = a + b + cin at full W+1 bit precision.
//   a, b   : W-bit operands
//   cin    : carry-in
//   sum_c  : {carry-out, sum}, combinational
module adder_golden #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W:0]   sum_c
);

    assign sum_c = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for adder labs. Accepts {a,b,cin,cout,z} vectors on a
// valid/ready handshake, compares each against a golden sum, counts vectors
// and mismatches, captures the first failing vector and flags stimulus that
// arrives out of exhaustive-sweep order.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a run (honoured in IDLE or DONE only)
//   in_valid / in_ready : vector handshake; in_ready high only in RUN
//   a, b, cin, z, cout  : applied stimulus and DUT response
//   busy, done, pass    : run status; pass qualified by done
//   vec_count, err_count: accepted vectors / mismatches (saturating)
//   order_err           : sticky out-of-order flag
//   first_fail          : {a,b,cin,cout,z} of the first mismatch
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NVEC  = nvec_f(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    input  logic [W-1:0]     z,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             order_err,
    output logic [3*W+1:0]   first_fail
);

    localparam int unsigned IDX_W = 2 * W + 1;
    localparam int unsigned FF_W  = 3 * W + 2;
    localparam int unsigned CMP_W = (CNT_W > IDX_W) ? CNT_W : IDX_W;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               order_err_q, order_err_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [FF_W-1:0]    first_fail_q, first_fail_d;

    logic [W:0]         gold_c;
    logic [IDX_W-1:0]   idx_c;
    logic               accept_c;
    logic               mismatch_c;

    adder_golden #(.W(W)) u_golden (
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum_c (gold_c)
    );

    // Next-state, counters and capture.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        order_err_d  = order_err_q;
        vec_count_d  = vec_count_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;

        idx_c      = {a, b, cin};
        accept_c   = in_valid & in_ready_q;
        mismatch_c = ({cout, z} != gold_c);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    in_ready_d   = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    order_err_d  = 1'b0;
                    vec_count_d  = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    vec_count_d = vec_count_q + CNT_W'(1);
                    if (mismatch_c) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (err_count_q == '0) begin
                            first_fail_d = {idx_c, cout, z};
                        end
                    end
                    // Sweep order is a outermost, cin innermost: index must track count.
                    if (CMP_W'(idx_c) != CMP_W'(vec_count_q)) begin
                        order_err_d = 1'b1;
                    end
                    if (vec_count_q == CNT_W'(NVEC - 1)) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        pass_d     = (err_count_d == '0) && !order_err_d;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                in_ready_d   = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b0;
                pass_d       = 1'b0;
                order_err_d  = 1'b0;
                vec_count_d  = '0;
                err_count_d  = '0;
                first_fail_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            order_err_q  <= 1'b0;
            vec_count_q  <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            order_err_q  <= order_err_d;
            vec_count_q  <= vec_count_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign order_err  = order_err_q;
    assign vec_count  = vec_count_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;

endmodule
